// File: rtl/prefetch_pkg.sv
// Shared definitions for the instruction prefetch stage: reset values,
// fetch FSM states and queue sizing.
package prefetch_pkg;

  localparam logic [15:0] RESET_CS = 16'hFFFF;
  localparam logic [15:0] RESET_IP = 16'h0000;

  localparam int FIFO_DEPTH_DEFAULT = 6;
  // Wide enough for occupancy/free counts up to the maximum depth of 8.
  localparam int CNT_W = 4;

  typedef enum logic {
    PF_IDLE,
    PF_FETCH
  } pf_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Byte queue for the prefetch stage: 0/1/2-byte push, 1-byte pop with a
// registered read port, flush, and a free-slot count that accounts for this cycle's pop.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       push_cnt,
  input  logic [7:0]       push_lo,
  input  logic [7:0]       push_hi,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] free_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  assign pop_ok   = pop && (count != '0);
  assign empty    = (count == '0);
  assign free_cnt = CNT_W'(DEPTH) - count + {{(CNT_W-1){1'b0}}, pop_ok};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      rd_data <= 8'h00;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= ptr_add(rd_ptr, 2'd1);
      end
      wr_ptr <= ptr_add(wr_ptr, push_cnt);
      count  <= count + {2'b00, push_cnt} - {{(CNT_W-1){1'b0}}, pop_ok};
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone
  // decide which entries are valid, so it can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_lo;
      if (push_cnt == 2'd2) mem[ptr_add(wr_ptr, 2'd1)] <= push_hi;
    end
  end

endmodule

// File: rtl/prefetch.sv
// Instruction prefetch: fetches 16-bit words at CS:IP, splits them into bytes
// and queues them for the decoder; load_new_ip flushes and redirects.
module prefetch
  import prefetch_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty,
  output logic        mem_access,
  input  logic        mem_ack,
  output logic [18:0] mem_address,
  input  logic [15:0] mem_data
);

  pf_state_t        state, state_next;
  logic [15:0]      cs;
  logic [15:0]      fetch_ip;
  logic             discard;
  logic             start;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] need;
  logic [18:0]      word_addr;
  logic             ack_take;
  logic             push_ok;
  logic [1:0]       push_cnt;
  logic [7:0]       push_lo;

  // Word address of ({cs,4'b0} + ip) >> 1; the segment term has no bit 0,
  // so dropping ip[0] first gives the same 19-bit result, wrapping at 1 MiB.
  assign word_addr = {cs, 3'b000} + {4'b0000, fetch_ip[15:1]};
  assign need      = fetch_ip[0] ? CNT_W'(1) : CNT_W'(2);

  assign ack_take  = (state == PF_FETCH) && mem_ack;
  assign push_ok   = ack_take && !discard && !load_new_ip;
  assign push_cnt  = push_ok ? (fetch_ip[0] ? 2'd1 : 2'd2) : 2'd0;
  assign push_lo   = fetch_ip[0] ? mem_data[15:8] : mem_data[7:0];

  assign mem_access = (state == PF_FETCH);

  prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (load_new_ip),
    .push_cnt (push_cnt),
    .push_lo  (push_lo),
    .push_hi  (mem_data[15:8]),
    .pop      (fifo_rd_en && !load_new_ip),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .free_cnt (free_cnt)
  );

  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      PF_IDLE: begin
        if (!load_new_ip && (free_cnt >= need)) begin
          state_next = PF_FETCH;
          start      = 1'b1;
        end
      end
      PF_FETCH: begin
        if (mem_ack) state_next = PF_IDLE;
      end
      default: state_next = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= PF_IDLE;
      cs          <= RESET_CS;
      fetch_ip    <= RESET_IP;
      discard     <= 1'b0;
      mem_address <= '0;
    end else begin
      state <= state_next;
      // Address is captured at request start so a redirect cannot disturb it.
      if (start) mem_address <= word_addr;
      if (load_new_ip) begin
        cs       <= new_cs;
        fetch_ip <= new_ip;
      end else if (push_ok) begin
        fetch_ip <= fetch_ip + (fetch_ip[0] ? 16'd1 : 16'd2);
      end
      if (ack_take) discard <= 1'b0;
      else if (load_new_ip && (state == PF_FETCH)) discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prefetch.sv
// Self-checking bench for prefetch: a table of redirect vectors plus directed
// sequences for fill/backpressure, redirect during fetch and empty-read corners.
module tb_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_new_ip;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        mem_access;
  logic        mem_ack;
  logic [18:0] mem_address;
  logic [15:0] mem_data;

  int errors = 0;
  int checks = 0;

  // Memory responder controls
  logic        mem_hold  = 1'b1;
  int          resp_lat  = 0;
  logic [15:0] resp_data = 16'h0000;

  prefetch dut (
    .clk          (clk),
    .reset        (reset),
    .load_new_ip  (load_new_ip),
    .new_cs       (new_cs),
    .new_ip       (new_ip),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .mem_access   (mem_access),
    .mem_ack      (mem_ack),
    .mem_address  (mem_address),
    .mem_data     (mem_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Responder: acks resp_lat cycles into a request unless held; verifies the
  // request address stayed stable from the first request cycle to the ack.
  initial begin : responder
    int          wcnt;
    logic        req_seen;
    logic [18:0] req_addr;
    wcnt     = 0;
    req_seen = 1'b0;
    req_addr = '0;
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wcnt     = 0;
        req_seen = 1'b0;
      end else if (mem_access) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          req_addr = mem_address;
        end
        if (!mem_hold) begin
          if (wcnt >= resp_lat) begin
            mem_ack  = 1'b1;
            mem_data = resp_data;
            check("addr_stable_to_ack", 32'(mem_address), 32'(req_addr));
          end else begin
            wcnt++;
          end
        end
      end else begin
        wcnt     = 0;
        req_seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Sample/drive point: just after the falling edge, away from posedge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic do_load, input logic [15:0] cs_v, input logic [15:0] ip_v);
    reset       = 1'b0;
    load_new_ip = 1'b0;
    fifo_rd_en  = 1'b0;
    step();
    step();
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_rd_data", 32'(fifo_rd_data), 32'h0);
    check("rst_mem_access", 32'(mem_access), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    reset       = 1'b1;
    load_new_ip = do_load;
    new_cs      = cs_v;
    new_ip      = ip_v;
    step();
    load_new_ip = 1'b0;
  endtask

  task automatic wait_access(input string name);
    int n = 0;
    while (!mem_access && n < 20) begin
      step();
      n++;
    end
    if (!mem_access) check({name, "_access_timeout"}, 32'(mem_access), 32'd1);
  endtask

  // Lets the responder complete exactly one request, then holds it again.
  task automatic wait_ack(input string name);
    int n = 0;
    mem_hold = 1'b0;
    do begin
      step();
      n++;
    end while (!mem_ack && n < 20);
    mem_hold = 1'b1;
    if (!mem_ack) check({name, "_ack_timeout"}, 32'(mem_ack), 32'd1);
  endtask

  task automatic pop(input string name, input logic [7:0] exp_b);
    int n = 0;
    while (fifo_empty && n < 20) begin
      step();
      n++;
    end
    if (fifo_empty) check({name, "_data_timeout"}, 32'(fifo_empty), 32'd0);
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    check(name, 32'(fifo_rd_data), 32'(exp_b));
  endtask

  typedef struct {
    logic [15:0] cs;
    logic [15:0] ip;
    logic [15:0] data;
    logic [18:0] addr1;
    logic [18:0] addr2;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        empty1;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    int n;
    logic ok;
    reset       = 1'b0;
    load_new_ip = 1'b0;
    new_cs      = 16'h0000;
    new_ip      = 16'h0000;
    fifo_rd_en  = 1'b0;

    vecs[0] = '{16'h1000, 16'h0003, 16'hBBAA, 19'h08001, 19'h08002, 8'hBB, 8'hAA, 1'b1};
    vecs[1] = '{16'hFFFF, 16'hFFFE, 16'h5678, 19'h07FF7, 19'h7FFF8, 8'h78, 8'h56, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 16'hCDEF, 19'h00000, 19'h00001, 8'hEF, 8'hCD, 1'b0};
    vecs[3] = '{16'h1234, 16'h5679, 16'h9A01, 19'h0BCDC, 19'h0BCDD, 8'h9A, 8'h01, 1'b1};
    vecs[4] = '{16'hF000, 16'hFFFF, 16'h0102, 19'h7FFFF, 19'h78000, 8'h01, 8'h02, 1'b1};

    // Reset fetch with 2-cycle memory latency
    mem_hold  = 1'b1;
    resp_lat  = 2;
    resp_data = 16'h3412;
    do_reset(1'b0, 16'h0, 16'h0);
    wait_access("t1");
    check("t1_addr", 32'(mem_address), 32'h7FFF8);
    wait_ack("t1");
    check("t1_empty_at_ack", 32'(fifo_empty), 32'd1);
    step();
    check("t1_empty_after_ack", 32'(fifo_empty), 32'd0);
    pop("t1_byte0", 8'h12);
    pop("t1_byte1", 8'h34);
    wait_access("t1n");
    check("t1_next_addr", 32'(mem_address), 32'h7FFF9);
    resp_lat = 0;

    // Redirect vectors
    for (int i = 0; i < 5; i++) begin
      mem_hold  = 1'b1;
      resp_data = vecs[i].data;
      do_reset(1'b1, vecs[i].cs, vecs[i].ip);
      wait_access("vec");
      check($sformatf("vec%0d_addr1", i), 32'(mem_address), 32'(vecs[i].addr1));
      wait_ack("vec");
      step();
      wait_access("vec");
      check($sformatf("vec%0d_addr2", i), 32'(mem_address), 32'(vecs[i].addr2));
      pop($sformatf("vec%0d_b0", i), vecs[i].b0);
      check($sformatf("vec%0d_empty1", i), 32'(fifo_empty), 32'(vecs[i].empty1));
      wait_ack("vec");
      pop($sformatf("vec%0d_b1", i), vecs[i].b1);
    end

    // Fill without pops, then backpressure release at even IP
    mem_hold  = 1'b0;
    resp_data = 16'h3412;
    do_reset(1'b0, 16'h0, 16'h0);
    repeat (30) step();
    check("fill_idle", 32'(mem_access), 32'd0);
    mem_hold = 1'b1;
    pop("fill_pop1", 8'h12);
    ok = 1'b1;
    repeat (4) begin
      step();
      if (mem_access) ok = 1'b0;
    end
    check("fill_no_fetch_one_free", 32'(ok), 32'd1);
    pop("fill_pop2", 8'h34);
    check("fill_fetch_two_free", 32'(mem_access), 32'd1);
    check("fill_fetch_addr", 32'(mem_address), 32'h7FFFB);
    n = 0;
    fifo_rd_en = 1'b1;
    while (!fifo_empty && n < 10) begin
      step();
      n++;
    end
    fifo_rd_en = 1'b0;
    check("fill_remaining_bytes", 32'(n), 32'd4);

    // Redirect (twice) during an outstanding fetch
    mem_hold = 1'b1;
    do_reset(1'b0, 16'h0, 16'h0);
    wait_access("t4");
    check("t4_old_addr", 32'(mem_address), 32'h7FFF8);
    new_cs = 16'h3000; new_ip = 16'h0000; load_new_ip = 1'b1;
    step();
    load_new_ip = 1'b0;
    step();
    new_cs = 16'h2000; new_ip = 16'h0010; load_new_ip = 1'b1;
    step();
    load_new_ip = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      step();
      if (!mem_access || mem_address != 19'h7FFF8 || !fifo_empty) ok = 1'b0;
    end
    check("t4_hold_old_request", 32'(ok), 32'd1);
    resp_data = 16'hDEAD;
    wait_ack("t4");
    resp_data = 16'hCAFE;
    check("t4_empty_at_ack", 32'(fifo_empty), 32'd1);
    step();
    check("t4_discarded", 32'(fifo_empty), 32'd1);
    wait_access("t4n");
    check("t4_new_addr", 32'(mem_address), 32'h10008);
    wait_ack("t4n");
    pop("t4_byte0", 8'hFE);
    pop("t4_byte1", 8'hCA);

    // Redirect coincident with the ack
    mem_hold = 1'b1;
    do_reset(1'b0, 16'h0, 16'h0);
    wait_access("t5");
    resp_data = 16'h5566;
    mem_hold  = 1'b0;
    step();
    mem_hold = 1'b1;
    check("t5_ack_now", 32'(mem_ack), 32'd1);
    resp_data = 16'h7788;
    new_cs = 16'h0000; new_ip = 16'h0100; load_new_ip = 1'b1;
    step();
    load_new_ip = 1'b0;
    check("t5_flushed", 32'(fifo_empty), 32'd1);
    step();
    check("t5_discarded", 32'(fifo_empty), 32'd1);
    wait_access("t5n");
    check("t5_new_addr", 32'(mem_address), 32'h00080);
    wait_ack("t5n");
    pop("t5_byte0", 8'h88);
    pop("t5_byte1", 8'h77);

    // Read on empty queue, then read together with redirect
    mem_hold  = 1'b1;
    resp_data = 16'h3412;
    do_reset(1'b0, 16'h0, 16'h0);
    wait_access("t6");
    wait_ack("t6");
    pop("t6_byte0", 8'h12);
    pop("t6_byte1", 8'h34);
    fifo_rd_en = 1'b1;
    repeat (4) begin
      step();
      check("t6_empty_rd_hold", 32'(fifo_rd_data), 32'h34);
      check("t6_empty_stays", 32'(fifo_empty), 32'd1);
    end
    fifo_rd_en = 1'b0;
    wait_access("t6n");
    wait_ack("t6n");
    step();
    check("t6_refilled", 32'(fifo_empty), 32'd0);
    pop("t6_byte2", 8'h12);
    fifo_rd_en = 1'b1;
    new_cs = 16'h0000; new_ip = 16'h0000; load_new_ip = 1'b1;
    step();
    fifo_rd_en  = 1'b0;
    load_new_ip = 1'b0;
    check("t6_pop_suppressed", 32'(fifo_rd_data), 32'h12);
    check("t6_flush_empty", 32'(fifo_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
